// File: rtl/fp_pkg.sv
// Shared FP32 format constants, rounding-mode encodings and the result flag layout
// used across the multiplier back end.
package fp_pkg;

    localparam int WIDTH     = 32;
    localparam int EXP_WIDTH = 8;
    localparam int SIG_WIDTH = 23;
    localparam int BIAS      = 127;

    typedef enum logic [1:0] {
        RND_RNE = 2'b00,
        RND_RTZ = 2'b01,
        RND_RUP = 2'b10,
        RND_RDN = 2'b11
    } rnd_e;

    typedef struct packed {
        logic ovf;
        logic unf;
        logic inexact;
    } flags_t;

    localparam logic [WIDTH-1:0] code_NaN   = 32'h7FC0_0000;
    localparam logic [WIDTH-1:0] code_PINF  = 32'h7F80_0000;
    localparam logic [WIDTH-1:0] code_NINF  = 32'hFF80_0000;
    localparam logic [WIDTH-1:0] MAX_FINITE = 32'h7F7F_FFFF;

endpackage

// File: rtl/fp_round_incr.sv
// Rounding decision: whether to bump the fraction by one ulp, and whether precision was lost.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module fp_round_incr
    import fp_pkg::*;
(
    input  logic [1:0] rnd_i,
    input  logic       sign_i,
    input  logic       l_i,
    input  logic       g_i,
    input  logic       t_i,
    output logic       inc_o,
    output logic       inexact_o
);

    always_comb begin
        inc_o = 1'b0;
        case (rnd_e'(rnd_i))
            RND_RNE: inc_o = g_i & (l_i | t_i);
            RND_RTZ: inc_o = 1'b0;
            RND_RUP: inc_o = ~sign_i & (g_i | t_i);
            RND_RDN: inc_o = sign_i & (g_i | t_i);
            default: inc_o = 1'b0;
        endcase
    end

    assign inexact_o = g_i | t_i;

endmodule

// File: rtl/fp_round_pack.sv
// Normalizes, rounds and packs the FP32 product; FP_ROUND_PACK_STICKY_FLAGS_EN adds sticky flags.
// Latency: 2 cycles accept->out_valid, throughput one result per cycle.
// Backpressure: out_ready low freezes the output stage; the stall propagates back to in_ready.
module fp_round_pack #(
    parameter int WIDTH     = fp_pkg::WIDTH,
    parameter int EXP_WIDTH = fp_pkg::EXP_WIDTH,
    parameter int SIG_WIDTH = fp_pkg::SIG_WIDTH,
    parameter int BIAS      = fp_pkg::BIAS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_sign,
    input  logic signed [EXP_WIDTH+1:0] in_exp,
    input  logic [2*SIG_WIDTH+1:0]      in_sig,
    input  logic                        in_zero,
    input  logic                        in_nan,
    input  logic                        in_inf,
    input  logic [1:0]                  rnd,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            result,
    output logic [2:0]                  out_flags
`ifdef FP_ROUND_PACK_STICKY_FLAGS_EN
    ,
    input  logic                        flags_clr,
    output logic [2:0]                  sticky_flags
`endif
);

    localparam int EW = EXP_WIDTH + 2;
    localparam int PW = 2*SIG_WIDTH + 2;
    localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
    localparam logic signed [EW-1:0] EXP_ZERO = '0;
    localparam logic signed [EW-1:0] EXP_OVF  = EW'(2*BIAS + 1);

    logic en1, en2;

    logic                 s1_valid_q;
    logic                 s1_sign_q;
    logic signed [EW-1:0] s1_exp_q, s1_exp_d;
    logic [SIG_WIDTH-1:0] s1_frac_q, s1_frac_d;
    logic                 s1_l_q, s1_l_d;
    logic                 s1_g_q, s1_g_d;
    logic                 s1_t_q, s1_t_d;
    fp_pkg::rnd_e         s1_rnd_q;
    logic                 s1_zero_q, s1_nan_q, s1_inf_q;

    logic                 out_valid_q;
    logic [WIDTH-1:0]     result_q, result_d;
    fp_pkg::flags_t       flags_q, flags_d;

    logic                 inc, inexact, toward_inf;
    logic [SIG_WIDTH:0]   frac_sum;
    logic signed [EW-1:0] exp_fin;

    assign en2      = ~out_valid_q | out_ready;
    assign en1      = ~s1_valid_q | en2;
    assign in_ready = en1;

    // A product in [2,4) drops one bit; that bit folds into the sticky term.
    always_comb begin
        if (in_sig[PW-1]) begin
            s1_frac_d = in_sig[PW-2:SIG_WIDTH+1];
            s1_l_d    = in_sig[SIG_WIDTH+1];
            s1_g_d    = in_sig[SIG_WIDTH];
            s1_t_d    = |in_sig[SIG_WIDTH-1:0];
            s1_exp_d  = in_exp + EXP_ONE;
        end else begin
            s1_frac_d = in_sig[PW-3:SIG_WIDTH];
            s1_l_d    = in_sig[SIG_WIDTH];
            s1_g_d    = in_sig[SIG_WIDTH-1];
            s1_t_d    = |in_sig[SIG_WIDTH-2:0];
            s1_exp_d  = in_exp;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_exp_q   <= '0;
            s1_frac_q  <= '0;
            s1_l_q     <= 1'b0;
            s1_g_q     <= 1'b0;
            s1_t_q     <= 1'b0;
            s1_rnd_q   <= fp_pkg::RND_RNE;
            s1_zero_q  <= 1'b0;
            s1_nan_q   <= 1'b0;
            s1_inf_q   <= 1'b0;
        end else if (en1) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_sign_q <= in_sign;
                s1_exp_q  <= s1_exp_d;
                s1_frac_q <= s1_frac_d;
                s1_l_q    <= s1_l_d;
                s1_g_q    <= s1_g_d;
                s1_t_q    <= s1_t_d;
                s1_rnd_q  <= fp_pkg::rnd_e'(rnd);
                s1_zero_q <= in_zero;
                s1_nan_q  <= in_nan;
                s1_inf_q  <= in_inf;
            end
        end
    end

    fp_round_incr u_round_incr (
        .rnd_i     (s1_rnd_q),
        .sign_i    (s1_sign_q),
        .l_i       (s1_l_q),
        .g_i       (s1_g_q),
        .t_i       (s1_t_q),
        .inc_o     (inc),
        .inexact_o (inexact)
    );

    // On carry-out the low fraction bits are already zero; only the exponent moves.
    assign frac_sum = {1'b0, s1_frac_q} + {{SIG_WIDTH{1'b0}}, inc};
    assign exp_fin  = s1_exp_q + (frac_sum[SIG_WIDTH] ? EXP_ONE : EXP_ZERO);

    always_comb begin
        toward_inf = 1'b0;
        case (s1_rnd_q)
            fp_pkg::RND_RNE: toward_inf = 1'b1;
            fp_pkg::RND_RTZ: toward_inf = 1'b0;
            fp_pkg::RND_RUP: toward_inf = ~s1_sign_q;
            fp_pkg::RND_RDN: toward_inf = s1_sign_q;
            default:         toward_inf = 1'b0;
        endcase
    end

    always_comb begin
        result_d         = {s1_sign_q, exp_fin[EXP_WIDTH-1:0], frac_sum[SIG_WIDTH-1:0]};
        flags_d          = '0;
        flags_d.inexact  = inexact;
        if (s1_nan_q) begin
            result_d = fp_pkg::code_NaN;
            flags_d  = '0;
        end else if (s1_inf_q) begin
            result_d = s1_sign_q ? fp_pkg::code_NINF : fp_pkg::code_PINF;
            flags_d  = '0;
        end else if (s1_zero_q) begin
            result_d = {s1_sign_q, {(WIDTH-1){1'b0}}};
            flags_d  = '0;
        end else if (exp_fin >= EXP_OVF) begin
            result_d = toward_inf ? (s1_sign_q ? fp_pkg::code_NINF : fp_pkg::code_PINF)
                                  : {s1_sign_q, fp_pkg::MAX_FINITE[WIDTH-2:0]};
            flags_d  = '{ovf: 1'b1, unf: 1'b0, inexact: 1'b1};
        end else if (exp_fin <= EXP_ZERO) begin
            result_d = {s1_sign_q, {(WIDTH-1){1'b0}}};
            flags_d  = '{ovf: 1'b0, unf: 1'b1, inexact: 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else if (en2) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                result_q <= result_d;
                flags_q  <= flags_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign out_flags = flags_q;

`ifdef FP_ROUND_PACK_STICKY_FLAGS_EN
    logic [2:0] sticky_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sticky_q <= '0;
        end else if (flags_clr) begin
            sticky_q <= '0;
        end else if (out_valid_q && out_ready) begin
            sticky_q <= sticky_q | flags_q;
        end
    end

    assign sticky_flags = sticky_q;
`endif

endmodule

// File: tb/tb_fp_round_pack.sv
// Bench for fp_round_pack: directed corner cases, randomized traffic against an arithmetic
// reference model, backpressure, mid-flight reset and (when enabled) sticky flags.
module tb_fp_round_pack;

    typedef struct {
        logic        sign;
        logic [9:0]  exp;
        logic [47:0] sig;
        logic        zero;
        logic        nan;
        logic        inf;
        logic [1:0]  rnd;
    } txn_t;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  flg;
    } out_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic              in_sign;
    logic signed [9:0] in_exp;
    logic [47:0]       in_sig;
    logic              in_zero, in_nan, in_inf;
    logic [1:0]        rnd;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       result;
    logic [2:0]        out_flags;
`ifdef FP_ROUND_PACK_STICKY_FLAGS_EN
    logic              flags_clr;
    logic [2:0]        sticky_flags;
`endif

    int   checks = 0;
    int   errors = 0;
    txn_t stim_q[$];
    out_t got_q[$];
    out_t exp_q[$];

    always #5 clk = ~clk;

    fp_round_pack dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sign      (in_sign),
        .in_exp       (in_exp),
        .in_sig       (in_sig),
        .in_zero      (in_zero),
        .in_nan       (in_nan),
        .in_inf       (in_inf),
        .rnd          (rnd),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .out_flags    (out_flags)
`ifdef FP_ROUND_PACK_STICKY_FLAGS_EN
        ,
        .flags_clr    (flags_clr),
        .sticky_flags (sticky_flags)
`endif
    );

    function automatic txn_t mk(input logic [47:0] sig, input int ex, input logic sign,
                                input logic [1:0] r, input logic z, input logic n, input logic i);
        txn_t t;
        t.sig = sig; t.exp = 10'(ex); t.sign = sign; t.rnd = r;
        t.zero = z; t.nan = n; t.inf = i;
        return t;
    endfunction

    // Reference: keep the top 24 significant bits, round on the exact discarded remainder.
    function automatic out_t model(input txn_t t);
        out_t            o;
        longint unsigned s, q, rem, half, one;
        int              sh, e;
        logic            inexact, up, toward;
        one   = 1;
        o.flg = 3'b000;
        if (t.nan)  begin o.res = 32'h7FC0_0000;          return o; end
        if (t.inf)  begin o.res = {t.sign, 8'hFF, 23'h0}; return o; end
        if (t.zero) begin o.res = {t.sign, 31'h0};        return o; end
        s       = 64'(t.sig);
        sh      = t.sig[47] ? 24 : 23;
        e       = int'($signed(t.exp)) + (t.sig[47] ? 1 : 0);
        q       = s >> sh;
        rem     = s & ((one << sh) - one);
        half    = one << (sh - 1);
        inexact = (rem != 0);
        case (t.rnd)
            2'b00:   up = (rem > half) || ((rem == half) && q[0]);
            2'b01:   up = 1'b0;
            2'b10:   up = !t.sign && inexact;
            default: up = t.sign && inexact;
        endcase
        if (up) q = q + one;
        if (q == (one << 24)) begin q = q >> 1; e = e + 1; end
        if (e >= 255) begin
            toward = (t.rnd == 2'b00) || (t.rnd == 2'b10 && !t.sign) || (t.rnd == 2'b11 && t.sign);
            o.res  = toward ? {t.sign, 8'hFF, 23'h0} : {t.sign, 8'hFE, 23'h7F_FFFF};
            o.flg  = 3'b101;
        end else if (e <= 0) begin
            o.res = {t.sign, 31'h0};
            o.flg = 3'b011;
        end else begin
            o.res = {t.sign, e[7:0], q[22:0]};
            o.flg = {2'b00, inexact};
        end
        return o;
    endfunction

    function automatic txn_t rand_txn();
        txn_t        t;
        logic [23:0] a, b;
        int          sel, ex;
        a   = {1'b1, 23'($urandom)};
        b   = {1'b1, 23'($urandom)};
        sel = int'($urandom_range(0, 9));
        if (sel < 6)      ex = int'($urandom_range(90, 160));
        else if (sel < 8) ex = int'($urandom_range(0, 508)) - 127;
        else if (sel < 9) ex = int'($urandom_range(251, 255));
        else              ex = int'($urandom_range(0, 3)) - 2;
        t = mk(48'(a) * 48'(b), ex, 1'($urandom), 2'($urandom),
               $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0);
        return t;
    endfunction

    task automatic drive(input txn_t t);
        in_sign = t.sign; in_exp = t.exp; in_sig = t.sig;
        in_zero = t.zero; in_nan = t.nan; in_inf = t.inf; rnd = t.rnd;
    endtask

    task automatic add(input txn_t t, input logic [31:0] res, input logic [2:0] flg);
        out_t o;
        o.res = res; o.flg = flg;
        stim_q.push_back(t);
        exp_q.push_back(o);
    endtask

    task automatic run_stream(input int stall_pct, input int budget);
        int idx = 0;
        int cyc = 0;
        out_t o;
        got_q.delete();
        while ((idx < stim_q.size() || got_q.size() < stim_q.size()) && cyc < budget) begin
            @(negedge clk);
            if (idx < stim_q.size() && int'($urandom_range(0, 99)) >= stall_pct) begin
                drive(stim_q[idx]);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = (int'($urandom_range(0, 99)) >= stall_pct);
            #1;
            if (in_valid && in_ready) idx++;
            if (out_valid && out_ready) begin
                o.res = result; o.flg = out_flags;
                got_q.push_back(o);
            end
            cyc++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        drive(mk(48'h0, 0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
`ifdef FP_ROUND_PACK_STICKY_FLAGS_EN
        flags_clr = 1'b0;
`endif
        #2 rst = 1'b0;
        #10;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", result); end
        checks++;
        if (out_flags !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", out_flags); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
`ifdef FP_ROUND_PACK_STICKY_FLAGS_EN
        checks++;
        if (sticky_flags !== 3'b000) begin errors++; $display("FAIL reset_sticky: got %b expected 000", sticky_flags); end
`endif
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_latency();
        @(negedge clk);
        drive(mk(48'h9000_0000_0000, 127, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL lat_in_ready: got %b expected 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_early: out_valid %b expected 0 after one cycle", out_valid); end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || result !== 32'h4010_0000 || out_flags !== 3'b000) begin
            errors++;
            $display("FAIL lat_result: got v=%b %h/%b expected v=1 40100000/000", out_valid, result, out_flags);
        end
    endtask

    task automatic test_directed();
        stim_q.delete(); exp_q.delete();
        add(mk(48'h4000_0040_0000, 127, 1'b0, 2'b00, 0, 0, 0), 32'h3F80_0000, 3'b001);
        add(mk(48'h4000_0040_0000, 127, 1'b0, 2'b10, 0, 0, 0), 32'h3F80_0001, 3'b001);
        add(mk(48'h4000_0040_0000, 127, 1'b0, 2'b01, 0, 0, 0), 32'h3F80_0000, 3'b001);
        add(mk(48'h4000_00C0_0000, 127, 1'b0, 2'b00, 0, 0, 0), 32'h3F80_0002, 3'b001);
        add(mk(48'hFFFF_FE00_0001, 254, 1'b0, 2'b00, 0, 0, 0), 32'h7F80_0000, 3'b101);
        add(mk(48'hFFFF_FE00_0001, 254, 1'b0, 2'b01, 0, 0, 0), 32'h7F7F_FFFF, 3'b101);
        add(mk(48'hFFFF_FE00_0001, 254, 1'b1, 2'b10, 0, 0, 0), 32'hFF7F_FFFF, 3'b101);
        add(mk(48'hFFFF_FE00_0001, 254, 1'b1, 2'b11, 0, 0, 0), 32'hFF80_0000, 3'b101);
        add(mk(48'hFFFF_FE00_0001, 254, 1'b0, 2'b11, 0, 0, 0), 32'h7F7F_FFFF, 3'b101);
        add(mk(48'h4000_0000_0000, -10, 1'b1, 2'b00, 0, 0, 0), 32'h8000_0000, 3'b011);
        add(mk(48'h4000_0000_0000, 127, 1'b0, 2'b00, 0, 1, 1), 32'h7FC0_0000, 3'b000);
        add(mk(48'h4000_0000_0000, 127, 1'b1, 2'b00, 0, 0, 1), 32'hFF80_0000, 3'b000);
        add(mk(48'h4000_0000_0000, 200, 1'b1, 2'b00, 1, 0, 0), 32'h8000_0000, 3'b000);
        add(mk(48'h7FFF_FFC0_0000, 127, 1'b0, 2'b00, 0, 0, 0), 32'h4000_0000, 3'b001);
        add(mk(48'h4000_0000_0000,   0, 1'b0, 2'b00, 0, 0, 0), 32'h0000_0000, 3'b011);
        add(mk(48'h4000_0000_0000,   1, 1'b0, 2'b00, 0, 0, 0), 32'h0080_0000, 3'b000);
        run_stream(0, 200);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL dir_count: got %0d results expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i].res !== exp_q[i].res || got_q[i].flg !== exp_q[i].flg) begin
                errors++;
                $display("FAIL dir_%0d: got %h/%b expected %h/%b", i, got_q[i].res, got_q[i].flg,
                         exp_q[i].res, exp_q[i].flg);
            end
        end
    endtask

    task automatic test_random();
        out_t e;
        stim_q.delete();
        for (int i = 0; i < 400; i++) stim_q.push_back(rand_txn());
        run_stream(25, 20000);
        checks++;
        if (got_q.size() != stim_q.size()) begin
            errors++;
            $display("FAIL rand_count: got %0d results expected %0d", got_q.size(), stim_q.size());
        end
        for (int i = 0; i < got_q.size() && i < stim_q.size(); i++) begin
            e = model(stim_q[i]);
            checks++;
            if (got_q[i].res !== e.res || got_q[i].flg !== e.flg) begin
                errors++;
                $display("FAIL rand_%0d: got %h/%b expected %h/%b (sig %h exp %0d rnd %b)", i,
                         got_q[i].res, got_q[i].flg, e.res, e.flg, stim_q[i].sig,
                         $signed(stim_q[i].exp), stim_q[i].rnd);
            end
        end
    endtask

    task automatic test_back_to_back();
        txn_t t[3];
        out_t e, held, o;
        int   idx = 0;
        bit   have = 0;
        bit   stable = 1;
        for (int i = 0; i < 3; i++) t[i] = rand_txn();
        got_q.delete();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            out_ready = 1'b0;
            if (idx < 3) begin drive(t[idx]); in_valid = 1'b1; end else in_valid = 1'b0;
            #1;
            if (out_valid) begin
                if (!have) begin held.res = result; held.flg = out_flags; have = 1; end
                else if (result !== held.res || out_flags !== held.flg) stable = 0;
            end
            if (in_valid && in_ready) idx++;
        end
        checks++;
        if (idx != 2) begin errors++; $display("FAIL bp_accepted: got %0d expected 2", idx); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
        e = model(t[0]);
        checks++;
        if (!have || held.res !== e.res || held.flg !== e.flg) begin
            errors++;
            $display("FAIL bp_head: got valid=%0d %h/%b expected %h/%b", have, held.res, held.flg, e.res, e.flg);
        end
        checks++;
        if (!stable) begin errors++; $display("FAIL bp_stable: output changed while stalled, expected held"); end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (idx < 3) begin drive(t[idx]); in_valid = 1'b1; end else in_valid = 1'b0;
            #1;
            if (in_valid && in_ready) idx++;
            if (out_valid && out_ready) begin o.res = result; o.flg = out_flags; got_q.push_back(o); end
        end
        in_valid = 1'b0;
        checks++;
        if (got_q.size() != 3) begin errors++; $display("FAIL bp_count: got %0d results expected 3", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 3; i++) begin
            e = model(t[i]);
            checks++;
            if (got_q[i].res !== e.res || got_q[i].flg !== e.flg) begin
                errors++;
                $display("FAIL bp_order_%0d: got %h/%b expected %h/%b", i, got_q[i].res, got_q[i].flg, e.res, e.flg);
            end
        end
    endtask

    task automatic test_reset_midflight();
        txn_t t[2];
        txn_t tn;
        out_t e;
        int   idx = 0;
        for (int i = 0; i < 2; i++) t[i] = mk(48'h4800_0000_0000, 130 + i, 1'b0, 2'b00, 0, 0, 0);
        for (int c = 0; c < 10 && idx < 2; c++) begin
            @(negedge clk);
            out_ready = 1'b0;
            drive(t[idx]); in_valid = 1'b1;
            #1;
            if (in_ready) idx++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL rstm_full: out_valid %b expected 1 before reset", out_valid); end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || result !== 32'h0 || out_flags !== 3'b000) begin
            errors++;
            $display("FAIL rstm_clear: got v=%b %h/%b expected v=0 00000000/000", out_valid, result, out_flags);
        end
        @(negedge clk);
        #1;
        rst = 1'b1;
        tn = mk(48'h6000_0000_0000, 100, 1'b1, 2'b01, 0, 0, 0);
        stim_q.delete();
        stim_q.push_back(tn);
        run_stream(0, 50);
        e = model(tn);
        checks++;
        if (got_q.size() != 1 || got_q[0].res !== e.res || got_q[0].flg !== e.flg) begin
            errors++;
            $display("FAIL rstm_first: got %0d results, first %h expected 1 result %h",
                     got_q.size(), (got_q.size() > 0) ? got_q[0].res : 32'h0, e.res);
        end
    endtask

`ifdef FP_ROUND_PACK_STICKY_FLAGS_EN
    task automatic test_sticky();
        bit seen = 0;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1; flags_clr = 1'b1;
        @(negedge clk);
        flags_clr = 1'b0;
        #1;
        checks++;
        if (sticky_flags !== 3'b000) begin errors++; $display("FAIL sticky_clear: got %b expected 000", sticky_flags); end
        stim_q.delete();
        stim_q.push_back(mk(48'hFFFF_FE00_0001, 254, 1'b0, 2'b00, 0, 0, 0));
        run_stream(0, 50);
        checks++;
        if (sticky_flags !== 3'b101) begin errors++; $display("FAIL sticky_ovf: got %b expected 101", sticky_flags); end
        stim_q.delete();
        stim_q.push_back(mk(48'h4000_0000_0000, -5, 1'b1, 2'b00, 0, 0, 0));
        run_stream(0, 50);
        checks++;
        if (sticky_flags !== 3'b111) begin errors++; $display("FAIL sticky_acc: got %b expected 111", sticky_flags); end
        @(negedge clk);
        out_ready = 1'b0;
        drive(mk(48'h4000_0000_0000, -5, 1'b0, 2'b00, 0, 0, 0));
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            #1;
            if (out_valid) seen = 1;
        end
        flags_clr = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        flags_clr = 1'b0;
        #1;
        checks++;
        if (!seen || out_valid !== 1'b0 || sticky_flags !== 3'b000) begin
            errors++;
            $display("FAIL sticky_clr_wins: seen=%0d out_valid=%b sticky=%b expected seen=1 0 000", seen, out_valid, sticky_flags);
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_latency();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_midflight();
`ifdef FP_ROUND_PACK_STICKY_FLAGS_EN
        test_sticky();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
